// File: rtl/bus_master_port.sv
// Bus master port: takes one local command, requests the bus and, once granted,
// shifts address/write data out serially or collects serial read data.
module bus_master_port #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  cmd_ready,
    output logic                  rsp_valid,
    output logic                  rsp_error,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  bus_request,
    input  logic                  bus_grant_in,
    output logic                  transaction_done,
    output logic                  bus_out,
    output logic                  bus_out_valid,
    output logic                  bus_mode,
    input  logic                  bus_in,
    input  logic                  bus_in_valid,
    input  logic                  slave_ready,
    output logic [2:0]            dbg_state
);

    localparam int MAXW  = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
    localparam int CNT_W = $clog2(MAXW + 1);
    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_WIDTH - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [15:0]      TO_LAST   = 16'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_REQUEST, S_ADDR, S_WDATA, S_WAIT_SLAVE, S_RDATA, S_DONE
    } state_t;

    state_t                           r_state;
    logic                             r_write;
    logic [ADDR_WIDTH+DATA_WIDTH-1:0] r_sh;
    logic [DATA_WIDTH-1:0]            r_data;
    logic [CNT_W-1:0]                 r_bit_cnt;
    logic [15:0]                      r_to_cnt;
    logic                             r_cmd_ready;
    logic                             r_rsp_valid;
    logic                             r_rsp_error;
    logic [DATA_WIDTH-1:0]            r_rsp_rdata;
    logic                             r_bus_request;
    logic                             r_transaction_done;
    logic                             r_bus_out;
    logic                             r_bus_out_valid;
    logic                             r_bus_mode;

    logic [DATA_WIDTH-1:0] w_rd_next;
    logic                  w_timed_out;

    // Read data arrives LSB first, so a right shift leaves bit 0 in place after DATA_WIDTH bits.
    assign w_rd_next   = {bus_in, r_data[DATA_WIDTH-1:1]};
    assign w_timed_out = (r_to_cnt == TO_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state            <= S_IDLE;
            r_write            <= 1'b0;
            r_sh               <= '0;
            r_data             <= '0;
            r_bit_cnt          <= '0;
            r_to_cnt           <= '0;
            r_cmd_ready        <= 1'b1;
            r_rsp_valid        <= 1'b0;
            r_rsp_error        <= 1'b0;
            r_rsp_rdata        <= '0;
            r_bus_request      <= 1'b0;
            r_transaction_done <= 1'b0;
            r_bus_out          <= 1'b0;
            r_bus_out_valid    <= 1'b0;
            r_bus_mode         <= 1'b0;
        end else begin
            r_rsp_valid        <= 1'b0;
            r_rsp_error        <= 1'b0;
            r_transaction_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_write       <= cmd_write;
                        r_sh          <= {cmd_wdata, cmd_addr};
                        r_cmd_ready   <= 1'b0;
                        r_bus_request <= 1'b1;
                        r_state       <= S_REQUEST;
                    end
                end
                S_REQUEST: begin
                    if (bus_grant_in) begin
                        r_state         <= S_ADDR;
                        r_bit_cnt       <= '0;
                        r_bus_out_valid <= 1'b1;
                        r_bus_mode      <= r_write;
                        r_bus_out       <= r_sh[0];
                        r_sh            <= r_sh >> 1;
                    end
                end
                S_ADDR, S_WDATA, S_WAIT_SLAVE, S_RDATA: begin
                    if (!bus_grant_in) begin
                        // Grant lost: abandon without transaction_done, report error next cycle.
                        r_state         <= S_IDLE;
                        r_cmd_ready     <= 1'b1;
                        r_bus_request   <= 1'b0;
                        r_bus_out_valid <= 1'b0;
                        r_bus_out       <= 1'b0;
                        r_bus_mode      <= 1'b0;
                        r_rsp_valid     <= 1'b1;
                        r_rsp_error     <= 1'b1;
                    end else if ((r_state == S_ADDR && r_bit_cnt == ADDR_LAST && !r_write) ||
                                 (r_state == S_WDATA && r_bit_cnt == DATA_LAST)) begin
                        r_state         <= (r_state == S_ADDR) ? S_RDATA : S_WAIT_SLAVE;
                        r_bit_cnt       <= '0;
                        r_to_cnt        <= '0;
                        r_bus_out_valid <= 1'b0;
                        r_bus_out       <= 1'b0;
                        r_bus_mode      <= 1'b0;
                    end else if (r_state == S_ADDR || r_state == S_WDATA) begin
                        r_bus_out <= r_sh[0];
                        r_sh      <= r_sh >> 1;
                        if (r_state == S_ADDR && r_bit_cnt == ADDR_LAST) begin
                            r_state   <= S_WDATA;
                            r_bit_cnt <= '0;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + CNT_ONE;
                        end
                    end else if ((r_state == S_WAIT_SLAVE && slave_ready) ||
                                 (r_state == S_RDATA && bus_in_valid && r_bit_cnt == DATA_LAST) ||
                                 (!(r_state == S_RDATA && bus_in_valid) && w_timed_out)) begin
                        r_state            <= S_DONE;
                        r_bus_request      <= 1'b0;
                        r_transaction_done <= 1'b1;
                        r_rsp_valid        <= 1'b1;
                        if (r_state == S_RDATA && bus_in_valid) begin
                            r_data      <= w_rd_next;
                            r_rsp_rdata <= w_rd_next;
                            r_rsp_error <= 1'b0;
                        end else begin
                            r_rsp_error <= !(r_state == S_WAIT_SLAVE && slave_ready);
                        end
                    end else if (r_state == S_RDATA && bus_in_valid) begin
                        r_data    <= w_rd_next;
                        r_to_cnt  <= '0;
                        r_bit_cnt <= r_bit_cnt + CNT_ONE;
                    end else begin
                        r_to_cnt <= r_to_cnt + 16'd1;
                    end
                end
                S_DONE: begin
                    r_state     <= S_IDLE;
                    r_cmd_ready <= 1'b1;
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_cmd_ready <= 1'b1;
                end
            endcase
        end
    end

    assign cmd_ready        = r_cmd_ready;
    assign rsp_valid        = r_rsp_valid;
    assign rsp_error        = r_rsp_error;
    assign rsp_rdata        = r_rsp_rdata;
    assign bus_request      = r_bus_request;
    assign transaction_done = r_transaction_done;
    assign bus_out          = r_bus_out;
    assign bus_out_valid    = r_bus_out_valid;
    assign bus_mode         = r_bus_mode;
    assign dbg_state        = r_state;

endmodule

// File: doc/bus_master_port.md
Name: bus_master_port

Overview:
- Master-side interface that sits upstream of the system-bus arbiter.
- Accepts one local read/write command at a time and raises a bus request to the arbiter. Once granted, it serialises address and write data onto the 1-bit system bus, or collects serial read data.
- Pulses transaction_done so the arbiter can release and re-arbitrate the bus. One instance is used per master (m1, m2).

Parameters:
- ADDR_WIDTH, 12, address bits shifted per transaction (LSB first).
- DATA_WIDTH, 8, data bits per transaction (LSB first).
- TIMEOUT, 255, max cycles waited in WAIT_SLAVE or RDATA without progress before abort; 1..65535, internal counter 16 bits.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  local command present.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_WIDTH  target address.
- cmd_wdata  in  DATA_WIDTH  write data.
- cmd_ready  out  1  high only in IDLE; command accepted on edge with cmd_valid & cmd_ready.
- rsp_valid  out  1  one-cycle pulse at end of every accepted command.
- rsp_error  out  1  qualifies rsp_valid; 1 = timeout or grant loss.
- rsp_rdata  out  DATA_WIDTH  read data, valid with rsp_valid on a good read; holds last value otherwise.
- bus_request  out  1  request to arbiter (drives m1_request / m2_request).
- bus_grant_in  in  1  this master's grant from arbiter (m1_grant / m2_grant).
- transaction_done  out  1  one-cycle pulse to arbiter on completion or timeout.
- bus_out  out  1  serial address/write-data bit.
- bus_out_valid  out  1  bus_out carries a valid bit.
- bus_mode  out  1  latched cmd_write, driven during ADDR/WDATA, else 0.
- bus_in  in  1  serial read-data bit from slave.
- bus_in_valid  in  1  bus_in valid this cycle.
- slave_ready  in  1  slave has committed the write.

Behaviour:
- Reset (reset=0, async): state IDLE; all outputs 0 except cmd_ready=1; counters and latched command cleared. Reset mid-transfer drops the transfer with no rsp_valid and no transaction_done.
- The command is latched on acceptance; cmd_* inputs are ignored afterwards.
- IDLE -> REQUEST on accept.
- REQUEST: bus_request=1; waits indefinitely; moves to ADDR on the first edge where bus_grant_in=1.
- ADDR: ADDR_WIDTH cycles; bus_out_valid=1, bus_out=addr[bit_cnt], bit_cnt counts 0..ADDR_WIDTH-1. Then goes to WDATA (write) or RDATA (read).
- WDATA: DATA_WIDTH cycles; bus_out_valid=1, bus_out=wdata[bit_cnt]. Then goes to WAIT_SLAVE.
- WAIT_SLAVE: bus_out_valid=0; moves to DONE on the first edge with slave_ready=1. Minimum occupancy is 1 cycle even if slave_ready is already high.
- RDATA: on each edge with bus_in_valid=1, shifts bus_in into data[bit_cnt]. After the DATA_WIDTH-th bit, goes to DONE. bus_in_valid=0 cycles neither shift nor advance.
- Timeout: the counter resets on entry to WAIT_SLAVE/RDATA and on every bus_in_valid. If it reaches TIMEOUT, go to DONE with error. The transaction_done pulse still fires so the arbiter releases the bus.
- DONE: exactly 1 cycle; bus_request=0, transaction_done=1, rsp_valid=1, rsp_error per outcome, rsp_rdata updated on a good read. Next state is IDLE.
- bus_request is 1 in REQUEST, ADDR, WDATA, WAIT_SLAVE and RDATA, and 0 in IDLE and DONE.
- Grant loss: if bus_grant_in=0 in any of ADDR, WDATA, WAIT_SLAVE or RDATA, go straight to IDLE.
  - The next cycle pulses rsp_valid=1 and rsp_error=1, registered.
  - transaction_done is not pulsed.
  - bus_out_valid drops immediately.
- Good-path latency, counted as state occupancy with immediate grant:
  - Write: REQUEST 1 + ADDR_WIDTH + DATA_WIDTH + WAIT ≥1 + DONE 1 = 23 cycles at defaults.
  - Read: 1 + ADDR_WIDTH + DATA_WIDTH (if bus_in_valid is continuous) + DONE 1 = 22 cycles at defaults.
- Back-to-back: a new command can be accepted in the cycle after DONE (IDLE, cmd_ready=1).

Test Plan:
- Write 0xA5 to addr 0x3C1, grant and slave_ready held high:
  - bus_out carries 0x3C1 LSB-first over 12 cycles, then 0xA5 LSB-first over 8 cycles, bus_mode=1.
  - transaction_done and rsp_valid pulse for 1 cycle 22 edges after accept; rsp_error=0.
- Read addr 0x010, slave returns 0x5A serially with a 1-cycle gap of bus_in_valid=0 after bit 3:
  - Data shifts only on valid cycles.
  - rsp_valid with rsp_rdata=0x5A, rsp_error=0, transaction_done pulses once.
- Grant withheld 10 cycles:
  - bus_request stays 1 and bus_out_valid stays 0 throughout.
  - ADDR starts on the edge after grant rises; the transfer completes normally.
- Write with slave_ready never asserted, TIMEOUT=20:
  - DONE is entered 20 cycles into WAIT_SLAVE.
  - transaction_done=1, rsp_valid=1, rsp_error=1; then IDLE with cmd_ready=1.
- Grant dropped at ADDR bit 5:
  - bus_out_valid goes 0 immediately.
  - rsp_valid=1 and rsp_error=1 the following cycle, with no transaction_done; the next command is accepted normally.
- reset=0 asserted mid-WDATA, then released:
  - All outputs are 0 asynchronously, cmd_ready=1.
  - No rsp_valid or transaction_done; a fresh write completes correctly.
